// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter that shares one mode-FSM command port among NUM_REQ requesters.
// Enforces a minimum hold time and a revocation timeout, and recovers from corrupt state encodings.
module fsm_cmd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   cmd,
    input  logic [NUM_REQ-1:0]     rel,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             owner,
    output logic [2:0]             fsm_cmd,
    output logic                   fsm_cmd_valid,
    output logic                   busy,
    output logic                   err_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        GRANT = 3'b001,
        HOLD  = 3'b010,
        ERROR = 3'b011
    } state_t;

    logic [2:0]         state_reg;
    state_t             state;
    state_t             state_next;
    logic [2:0]         rr_ptr;
    logic [2:0]         rr_ptr_next;
    logic [7:0]         hold_cnt;
    logic [7:0]         hold_cnt_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [2:0]         owner_next;
    logic [2:0]         fsm_cmd_next;
    logic               valid_next;
    logic               busy_next;
    logic               err_next;
    logic               own_req;
    logic               own_rel;
    logic               release_ok;
    int                 cand;

    assign state = state_t'(state_reg);

    // grant is one-hot on the owner, so masking avoids indexing by owner
    assign own_req    = |(req & grant);
    assign own_rel    = |(rel & grant);
    assign release_ok = (hold_cnt >= 8'(HOLD_CYCLES)) && (!own_req || own_rel);

    // Descending scan so the nearest requester after rr_ptr wins
    always_comb begin
        cand = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                cand = (int'(rr_ptr) + k) % NUM_REQ;
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        owner_next    = owner;
        fsm_cmd_next  = fsm_cmd;
        valid_next    = 1'b0;
        busy_next     = busy;
        err_next      = 1'b0;
        rr_ptr_next   = rr_ptr;
        hold_cnt_next = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next   = GRANT;
                    grant_next   = NUM_REQ'(1) << cand;
                    owner_next   = 3'(cand);
                    fsm_cmd_next = cmd[3*cand +: 3];
                    valid_next   = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            GRANT: begin
                state_next    = HOLD;
                hold_cnt_next = 8'd1;
            end
            HOLD: begin
                if (release_ok) begin
                    state_next    = IDLE;
                    grant_next    = '0;
                    owner_next    = 3'd0;
                    rr_ptr_next   = owner;
                    busy_next     = 1'b0;
                    hold_cnt_next = 8'd0;
                end else if (hold_cnt == 8'(TIMEOUT)) begin
                    state_next    = ERROR;
                    grant_next    = '0;
                    owner_next    = 3'd0;
                    rr_ptr_next   = owner;
                    err_next      = 1'b1;
                    hold_cnt_next = 8'd0;
                end else if (hold_cnt < 8'(TIMEOUT)) begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            ERROR: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next    = IDLE;
                grant_next    = '0;
                owner_next    = 3'd0;
                fsm_cmd_next  = 3'd0;
                busy_next     = 1'b0;
                hold_cnt_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant         <= '0;
            owner         <= 3'd0;
            fsm_cmd       <= 3'd0;
            fsm_cmd_valid <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            rr_ptr        <= 3'(NUM_REQ - 1);
            hold_cnt      <= 8'd0;
        end else begin
            state_reg     <= state_next;
            grant         <= grant_next;
            owner         <= owner_next;
            fsm_cmd       <= fsm_cmd_next;
            fsm_cmd_valid <= valid_next;
            busy          <= busy_next;
            err_timeout   <= err_next;
            rr_ptr        <= rr_ptr_next;
            hold_cnt      <= hold_cnt_next;
        end
    end

endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Scoreboard bench for fsm_cmd_arbiter: grants and timeout pulses are queued when stimulus is issued
// and popped by a monitor whenever the DUT strobes fsm_cmd_valid or err_timeout.
module tb_fsm_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] cmd;
    logic [3:0]  rel;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic [2:0]  fsm_cmd;
    logic        fsm_cmd_valid;
    logic        busy;
    logic        err_timeout;

    typedef struct packed {
        logic       is_err;
        logic [3:0] grant;
        logic [2:0] owner;
        logic [2:0] cmd;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    fsm_cmd_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .cmd           (cmd),
        .rel           (rel),
        .grant         (grant),
        .owner         (owner),
        .fsm_cmd       (fsm_cmd),
        .fsm_cmd_valid (fsm_cmd_valid),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        req = r;
        rel = l;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic e, input logic [3:0] g, input logic [2:0] o, input logic [2:0] c);
        exp_t x;
        x.is_err = e;
        x.grant  = g;
        x.owner  = o;
        x.cmd    = c;
        exp_q.push_back(x);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (fsm_cmd_valid || err_timeout) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_event actual grant=%b valid=%b err=%b required=no event",
                             grant, fsm_cmd_valid, err_timeout);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("mon_err", 32'(err_timeout), 32'(e.is_err));
                    checkOutput("mon_valid", 32'(fsm_cmd_valid), 32'(!e.is_err));
                    checkOutput("mon_grant", 32'(grant), 32'(e.grant));
                    checkOutput("mon_owner", 32'(owner), 32'(e.owner));
                    if (!e.is_err) checkOutput("mon_cmd", 32'(fsm_cmd), 32'(e.cmd));
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        cmd   = {3'h7, 3'h5, 3'h3, 3'h1};
        applyStimulus(4'b0000, 4'b0000);
        fork
            monitor();
        join_none
        step();
        step();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_fsm_cmd", 32'(fsm_cmd), 32'd0);
        checkOutput("rst_valid", 32'(fsm_cmd_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);

        // Single request from requester 2
        rst = 1'b0;
        push(1'b0, 4'b0100, 3'd2, 3'h5);
        applyStimulus(4'b0100, 4'b0000);
        step();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        step();
        checkOutput("t1_valid_one_cycle", 32'(fsm_cmd_valid), 32'd0);
        step();
        applyStimulus(4'b0000, 4'b0000);
        step();
        checkOutput("t2_hold_cnt3_grant", 32'(grant), 32'b0100);
        step();
        checkOutput("t2_hold_cnt4_grant", 32'(grant), 32'b0100);
        step();
        checkOutput("t2_released_grant", 32'(grant), 32'd0);
        checkOutput("t2_released_owner", 32'(owner), 32'd0);
        checkOutput("t2_released_busy", 32'(busy), 32'd0);
        checkOutput("t2_fsm_cmd_kept", 32'(fsm_cmd), 32'h5);

        // Round-robin over four continuous requesters
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(1'b0, 4'b0001, 3'd0, 3'h1);
        push(1'b0, 4'b0010, 3'd1, 3'h3);
        push(1'b0, 4'b0100, 3'd2, 3'h5);
        push(1'b0, 4'b1000, 3'd3, 3'h7);
        push(1'b0, 4'b0001, 3'd0, 3'h1);
        applyStimulus(4'b1111, 4'b0000);
        step();
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            applyStimulus(4'b1111, 4'(1) << i);
            step();
            checkOutput("rr_released", 32'(grant), 32'd0);
            applyStimulus(4'b1111, 4'b0000);
            step();
        end

        // Owner 0 never releases; non-owner releases must be ignored
        push(1'b1, 4'b0000, 3'd0, 3'd0);
        push(1'b0, 4'b0010, 3'd1, 3'h3);
        repeat (8) step();
        applyStimulus(4'b1111, 4'b1110);
        step();
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("to_nonowner_rel_ignored", 32'(grant), 32'b0001);
        repeat (6) step();
        checkOutput("to_cnt15_grant", 32'(grant), 32'b0001);
        checkOutput("to_cnt15_busy", 32'(busy), 32'd1);
        step();
        checkOutput("to_error_grant", 32'(grant), 32'd0);
        checkOutput("to_error_busy", 32'(busy), 32'd1);
        step();
        checkOutput("to_idle_busy", 32'(busy), 32'd0);
        checkOutput("to_idle_grant", 32'(grant), 32'd0);
        step();
        checkOutput("to_regrant", 32'(grant), 32'b0010);

        // Reset in the middle of HOLD
        repeat (3) step();
        rst = 1'b1;
        step();
        checkOutput("rh_grant", 32'(grant), 32'd0);
        checkOutput("rh_owner", 32'(owner), 32'd0);
        checkOutput("rh_fsm_cmd", 32'(fsm_cmd), 32'd0);
        checkOutput("rh_busy", 32'(busy), 32'd0);
        checkOutput("rh_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        push(1'b0, 4'b0001, 3'd0, 3'h1);
        step();
        checkOutput("rh_regrant", 32'(grant), 32'b0001);

        // Corrupt state encoding must recover to IDLE
        repeat (2) step();
        applyStimulus(4'b0000, 4'b0000);
        force dut.state_reg = 3'b110;
        step();
        checkOutput("bad_state_grant", 32'(grant), 32'd0);
        checkOutput("bad_state_busy", 32'(busy), 32'd0);
        checkOutput("bad_state_owner", 32'(owner), 32'd0);
        release dut.state_reg;
        step();
        checkOutput("bad_state_idle", 32'(dut.state_reg), 32'd0);
        checkOutput("bad_state_busy_after", 32'(busy), 32'd0);

        step();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_cmd_arbiter.md
Name: fsm_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one mode FSM command port among NUM_REQ requesters.
- Grants exclusive ownership to one requester and forwards its 3-bit command to the FSM as a single-cycle valid pulse.
- Enforces a minimum hold time and a maximum ownership timeout.
- Uses a hardened state machine: all unused state encodings recover to IDLE.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- HOLD_CYCLES, 4, minimum cycles in HOLD before release is honoured; 1..TIMEOUT-1.
- TIMEOUT, 15, HOLD cycle count at which ownership is forcibly revoked; must be < 256.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset is synchronous and active-high.
- req  input  NUM_REQ  per-requester request level.
- cmd  input  3*NUM_REQ  per-requester command; slice i = cmd[3*i+2:3*i].
- rel  input  NUM_REQ  per-requester explicit release pulse.
- grant  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
- owner  output  3  index of current owner; 0 when grant is 0.
- fsm_cmd  output  3  command forwarded to the mode FSM.
- fsm_cmd_valid  output  1  one-cycle strobe qualifying fsm_cmd.
- busy  output  1  high in GRANT, HOLD and ERROR.
- err_timeout  output  1  one-cycle pulse on forced revocation.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; grant=0; owner=0; fsm_cmd=0; fsm_cmd_valid=0; busy=0; err_timeout=0; rr_ptr=NUM_REQ-1; hold_cnt=0. Reset overrides every other event, including mid-ownership; no release or error pulse is generated.
- State encoding (3-bit): IDLE=000, GRANT=001, HOLD=010, ERROR=011. Any other encoding transitions to IDLE on the next clock with all outputs at their reset values.
- IDLE:
  - If req != 0: winner = first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Next state GRANT; grant<=onehot(winner); owner<=winner; fsm_cmd<=cmd slice of winner, captured on this edge.
  - Otherwise stay in IDLE.
- GRANT (exactly 1 cycle): fsm_cmd_valid=1; next state HOLD; hold_cnt<=1.
- HOLD:
  - grant, owner and fsm_cmd held stable; fsm_cmd_valid=0; hold_cnt increments each cycle, saturating at TIMEOUT.
  - Release when hold_cnt >= HOLD_CYCLES and (req[owner]==0 or rel[owner]==1). Next state IDLE; grant<=0; owner<=0; rr_ptr<=owner.
  - Timeout when hold_cnt == TIMEOUT and release is not met. Next state ERROR; grant<=0; rr_ptr<=owner.
  - Release takes priority over timeout on the same cycle.
  - Release or deassertion before HOLD_CYCLES is ignored; it is sampled again on later cycles.
- ERROR (exactly 1 cycle): err_timeout=1; grant=0; next state IDLE.
- rel and req from non-owners are ignored while busy.
- Latency:
  - req rising in IDLE gives grant and fsm_cmd_valid 1 cycle later.
  - Earliest re-grant after release is 1 cycle after returning to IDLE, so minimum back-to-back spacing is HOLD_CYCLES+2 cycles.
- fsm_cmd retains its last value after release; it is meaningful only with fsm_cmd_valid.
- No combinational path from any input to any output.

Test Plan:
- Reset, then req=4'b0100 with cmd slice2=3'h5 -> next cycle grant=4'b0100, owner=2, fsm_cmd=5, fsm_cmd_valid=1 for one cycle only, busy=1.
- Requester 2 owns and drops req at hold_cnt=2 with HOLD_CYCLES=4 -> grant held; released when hold_cnt=4; grant=0 the following cycle.
- req=4'b1111 held continuously, each owner pulsing rel once hold_cnt>=4 -> grant sequence 0001, 0010, 0100, 1000, 0001 (round-robin wrap).
- Owner holds req and never releases -> at hold_cnt=15: ERROR, grant=0, err_timeout=1 for exactly one cycle, then IDLE; the next grant goes to a different pending requester.
- Assert rst during HOLD -> next cycle all outputs 0, state IDLE, no err_timeout; request still pending -> re-granted 1 cycle after rst deasserts.
- Force state register to 3'b110 via bench -> next cycle state=IDLE, grant=0, busy=0.
